// File: rtl/sa_response_checker.sv
// sa_response_checker: response side of the stuck-at test flow.
// Takes test vectors over valid/ready and holds each one on the CUT inputs.
// After SETTLE_CYC cycles it compares the faulty (z_obs) and fault-free
// (z_exp) outputs, then updates the mismatch/vector counters and the
// first-fail capture registers.
// Optional feature macro: SA_SIG_EN builds a SIG_W-bit MISR over z_obs.
// Without the macro, signature is tied to 0.
module sa_response_checker #(
  parameter int VEC_W      = 4,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int SIG_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [VEC_W-1:0] vec_in,
  input  logic             vec_last,
  output logic [VEC_W-1:0] vec_out,
  input  logic             z_obs,
  input  logic             z_exp,
  output logic             busy,
  output logic             done,
  output logic             fault_detected,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [SIG_W-1:0] signature
);

  // Settle counter is at least one bit wide so SETTLE_CYC=1 still elaborates.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

  state_t         state, nstate;
  logic [SW-1:0]  scnt;
  logic           last_q;
  logic           accept, sample, clear, miss;

  assign accept = (state == RUN) && vec_valid;
  assign sample = (state == SETTLE) && (scnt == '0);
  assign clear  = start && ((state == IDLE) || (state == DONE));
  // Plain inequality: an X on z_obs is not treated as a mismatch.
  assign miss   = (z_obs != z_exp);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next state and handshake/status decode.
  always_comb begin
    nstate    = state;
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) nstate = RUN;
      RUN: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
        if (vec_valid) nstate = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (scnt == '0) nstate = last_q ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        if (start) nstate = RUN;
      end
      default: nstate = IDLE;
    endcase
  end

  // Capture the accepted vector and run the settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out <= '0;
      last_q  <= 1'b0;
      scnt    <= '0;
    end else if (accept) begin
      vec_out <= vec_in;
      last_q  <= vec_last;
      scnt    <= SW'(SETTLE_CYC - 1);
    end else if ((state == SETTLE) && (scnt != '0)) begin
      scnt <= scnt - SW'(1);
    end
  end

  // Result registers. They clear on start and update only at the sample edge.
  // fault_detected doubles as the "first fail already captured" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_detected <= 1'b0;
      mismatch_cnt   <= '0;
      vec_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_idx <= '0;
    end else if (clear) begin
      fault_detected <= 1'b0;
      mismatch_cnt   <= '0;
      vec_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_idx <= '0;
    end else if (sample) begin
      if (vec_cnt != '1) vec_cnt <= vec_cnt + CNT_W'(1);
      if (miss) begin
        fault_detected <= 1'b1;
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!fault_detected) begin
          first_fail_vec <= vec_out;
          first_fail_idx <= vec_cnt;
        end
      end
    end
  end

`ifdef SA_SIG_EN
  localparam logic [SIG_W-1:0] SIG_POLY = SIG_W'('h1021);

  // MISR over z_obs, seeded with all-ones at session start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      signature <= '0;
    else if (clear)  signature <= '1;
    else if (sample) signature <= {signature[SIG_W-2:0], 1'b0}
                                  ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                                  ^ {{(SIG_W-1){1'b0}}, z_obs};
  end
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_sa_response_checker.sv
// Bench for sa_response_checker. Two instances share the stimulus: one with
// CNT_W=8 and one with CNT_W=2 so saturation is exercised. Expected results
// come from per-session queues of (vector, z_obs, mismatch) records.
module tb_sa_response_checker;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic [3:0] vec_in = 4'h0;
  logic       vec_last = 1'b0;
  logic       z_obs = 1'b0;
  logic       z_exp = 1'b0;

  logic       a_ready, a_busy, a_done, a_fd;
  logic [3:0] a_out, a_ffv;
  logic [7:0] a_mc, a_vc, a_ffi;
  logic [15:0] a_sig;
  logic       b_ready, b_busy, b_done, b_fd;
  logic [3:0] b_out, b_ffv;
  logic [1:0] b_mc, b_vc, b_ffi;
  logic [15:0] b_sig;

  sa_response_checker #(.VEC_W(4), .CNT_W(8), .SETTLE_CYC(SETTLE), .SIG_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(a_ready),
    .vec_in(vec_in), .vec_last(vec_last), .vec_out(a_out), .z_obs(z_obs), .z_exp(z_exp),
    .busy(a_busy), .done(a_done), .fault_detected(a_fd), .mismatch_cnt(a_mc), .vec_cnt(a_vc),
    .first_fail_vec(a_ffv), .first_fail_idx(a_ffi), .signature(a_sig));

  sa_response_checker #(.VEC_W(4), .CNT_W(2), .SETTLE_CYC(SETTLE), .SIG_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(b_ready),
    .vec_in(vec_in), .vec_last(vec_last), .vec_out(b_out), .z_obs(z_obs), .z_exp(z_exp),
    .busy(b_busy), .done(b_done), .fault_detected(b_fd), .mismatch_cnt(b_mc), .vec_cnt(b_vc),
    .first_fail_vec(b_ffv), .first_fail_idx(b_ffi), .signature(b_sig));

  always #5 clk = ~clk;

  localparam logic [15:0] SIG_MASK =
`ifdef SA_SIG_EN
    16'hFFFF;
`else
    16'h0000;
`endif

  int total = 0;
  int passed = 0;

  logic [3:0] mv[$];
  bit         mz[$];
  bit         mm[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // MISR reference: all-ones seed, POLY 0x1021, z_obs folded into bit 0.
  function automatic logic [15:0] sig_model();
    logic [15:0] s;
    s = 16'hFFFF;
    foreach (mz[i]) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'b0, mz[i]};
    return s & SIG_MASK;
  endfunction

  // Start a session; both instances must come up cleared in RUN.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    mv.delete(); mz.delete(); mm.delete();
    chk("start.ready", a_ready, 1);
    chk("start.busy", a_busy, 1);
    chk("start.done", a_done, 0);
    chk("start.vc", a_vc, 0);
    chk("start.mc", a_mc, 0);
    chk("start.fd", a_fd, 0);
    chk("start.sig", a_sig, 16'hFFFF & SIG_MASK);
  endtask

  // Present one vector with the CUT responses it should produce, wait for
  // acceptance, then measure the ready-low window and the result update.
  task automatic send(input logic [3:0] v, input bit lst, input bit zo, input bit ze);
    int w;
    w = 0;
    while (!a_ready && w < 50) begin @(negedge clk); w++; end
    chk("send.ready", a_ready, 1);
    vec_in = v; vec_last = lst; z_obs = zo; z_exp = ze; vec_valid = 1'b1;
    @(posedge clk);
    #1 vec_valid = 1'b0; vec_last = 1'b0;
    mv.push_back(v); mz.push_back(zo); mm.push_back(zo != ze);
    chk("send.vec_out", a_out, v);
    chk("send.vec_out_b", b_out, v);
    w = 0;
    @(negedge clk);
    while (!(a_ready || a_done) && w < 20) begin w++; @(negedge clk); end
    chk("send.settle_len", w, SETTLE);
    chk("send.vc", a_vc, sat(mv.size(), 255));
    chk("send.vc_b", b_vc, sat(mv.size(), 3));
    chk("send.sig", a_sig, sig_model());
  endtask

  // Compare the final results of both instances against the session record.
  task automatic check_session(input string tag);
    int n, nm, fi;
    n = mv.size(); nm = 0; fi = -1;
    foreach (mm[i]) if (mm[i]) begin nm++; if (fi < 0) fi = i; end
    chk({tag, ".done"}, a_done, 1);
    chk({tag, ".busy"}, a_busy, 0);
    chk({tag, ".fd"}, a_fd, nm > 0);
    chk({tag, ".mc"}, a_mc, sat(nm, 255));
    chk({tag, ".vc"}, a_vc, sat(n, 255));
    chk({tag, ".ffi"}, a_ffi, (fi < 0) ? 0 : sat(fi, 255));
    chk({tag, ".ffv"}, a_ffv, (fi < 0) ? 4'h0 : mv[fi]);
    chk({tag, ".sig"}, a_sig, sig_model());
    chk({tag, ".fd_b"}, b_fd, nm > 0);
    chk({tag, ".mc_b"}, b_mc, sat(nm, 3));
    chk({tag, ".vc_b"}, b_vc, sat(n, 3));
    chk({tag, ".ffi_b"}, b_ffi, (fi < 0) ? 0 : sat(fi, 3));
    chk({tag, ".ffv_b"}, b_ffv, (fi < 0) ? 4'h0 : mv[fi]);
  endtask

  initial begin
    logic [3:0] v;
    bit zo, ze;

    // Reset state.
    #1;
    chk("rst.ready", a_ready, 0);
    chk("rst.busy", a_busy, 0);
    chk("rst.done", a_done, 0);
    chk("rst.vec_out", a_out, 0);
    chk("rst.sig", a_sig, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // start and vec_valid together in IDLE: only start acts.
    @(negedge clk);
    start = 1'b1; vec_valid = 1'b1; vec_in = 4'hA;
    @(posedge clk);
    #1 start = 1'b0; vec_valid = 1'b0;
    chk("sv.ready", a_ready, 1);
    chk("sv.vec_out", a_out, 0);
    mv.delete(); mz.delete(); mm.delete();

    // B stuck-at-1 session: 0000, 0100, 0010(last).
    send(4'b0000, 0, 1, 0);
    send(4'b0100, 0, 1, 1);
    send(4'b0010, 1, 0, 0);
    check_session("b_sa1");
    chk("b_sa1.mc_direct", a_mc, 1);
    chk("b_sa1.ffi_direct", a_ffi, 0);

    // Reset in the middle of SETTLE after a recorded mismatch.
    do_start();
    send(4'h9, 0, 1, 0);
    @(negedge clk);
    vec_in = 4'h6; vec_valid = 1'b1;
    @(posedge clk);
    #1 vec_valid = 1'b0;
    chk("abort.vec_out_pre", a_out, 4'h6);
    rst_n = 1'b0;
    #1;
    chk("abort.vec_out", a_out, 0);
    chk("abort.busy", a_busy, 0);
    chk("abort.done", a_done, 0);
    chk("abort.ready", a_ready, 0);
    chk("abort.vc", a_vc, 0);
    chk("abort.mc", a_mc, 0);
    chk("abort.fd", a_fd, 0);
    chk("abort.ffv", a_ffv, 0);
    chk("abort.sig", a_sig, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-match session of 5 random vectors, then restart.
    do_start();
    for (int i = 0; i < 5; i++) begin
      zo = 1'($urandom);
      send(4'($urandom), i == 4, zo, zo);
    end
    check_session("match");
    do_start();

    // 8 vectors, mismatches at 3 and 6, a 4-cycle valid gap mid-run.
    for (int i = 0; i < 8; i++) begin
      ze = 1'($urandom);
      zo = (i == 3 || i == 6) ? !ze : ze;
      send(4'($urandom), i == 7, zo, ze);
      if (i == 3) begin
        repeat (4) begin
          @(negedge clk);
          chk("gap.ready", a_ready, 1);
          chk("gap.busy", a_busy, 1);
        end
      end
    end
    check_session("idx36");

    // 6 vectors all mismatching; start while busy must be ignored.
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(4'($urandom), i == 5, 1, 0);
      if (i == 1) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start.vc", a_vc, 2);
        chk("busy_start.mc_b", b_mc, 2);
        chk("busy_start.busy", a_busy, 1);
      end
    end
    check_session("sat");

    // Signature session: z_obs 1,0,1.
    do_start();
    send(4'h1, 0, 1, 1);
    send(4'h2, 0, 0, 0);
    send(4'h3, 1, 1, 0);
    check_session("sig");

    // Random session.
    do_start();
    for (int i = 0; i < 20; i++) begin
      ze = 1'($urandom);
      zo = ($urandom_range(0, 3) == 0) ? !ze : ze;
      send(4'($urandom), i == 19, zo, ze);
    end
    check_session("rand");

    // Long session: first fail lands after vec_cnt saturates.
    do_start();
    for (int i = 0; i < 260; i++) begin
      ze = 1'($urandom);
      send(4'($urandom), i == 259, (i == 258) ? !ze : ze, ze);
    end
    check_session("long");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sa_response_checker.md
Name: sa_response_checker

Overview:
Response-side counterpart of the stuck-at test-vector generator. Accepts test vectors over a valid/ready handshake and holds each one on the circuit-under-test inputs. After a programmable settle time it samples the observed output of the faulty circuit and the expected output of a fault-free instance, compares them, and records the result. Reports a fault-detected flag, a mismatch count, the first failing vector and its index, and optionally a MISR signature of the observed outputs.

Parameters:
VEC_W, 4, vector width (A,B,C,D order: vec_out[3]=A ... vec_out[0]=D)
CNT_W, 8, width of mismatch and index counters
SETTLE_CYC, 2, cycles between vector acceptance and output sampling (>=1)
SIG_W, 16, signature width (used only with SA_SIG_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: clear results and begin a session (honoured in IDLE or DONE only)
vec_valid  in  1  test vector valid
vec_ready  out  1  checker can accept a vector
vec_in  in  VEC_W  test vector
vec_last  in  1  marks final vector of session, sampled with vec_in
vec_out  out  VEC_W  vector applied to both circuit instances
z_obs  in  1  output of circuit with injected fault
z_exp  in  1  output of fault-free circuit
busy  out  1  session active (RUN or SETTLE)
done  out  1  session complete, held until next start
fault_detected  out  1  sticky: any mismatch seen this session
mismatch_cnt  out  CNT_W  mismatches, saturating
vec_cnt  out  CNT_W  vectors checked, saturating
first_fail_vec  out  VEC_W  vector of first mismatch
first_fail_idx  out  CNT_W  0-based index of first mismatch
signature  out  SIG_W  MISR of z_obs (0 without SA_SIG_EN)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (vec_out=0, vec_ready=0, done=0, counters and capture registers 0). Deassertion is synchronous to clk.
- States:
  - IDLE: on start go to RUN and clear all result registers.
  - RUN: vec_ready=1. On vec_valid&&vec_ready, register vec_in into vec_out and vec_last into last_q, load settle counter with SETTLE_CYC-1, go to SETTLE.
  - SETTLE: vec_ready=0; vec_out stays stable. Decrement the counter. When the counter is 0, sample z_obs/z_exp on that edge. Go to DONE if last_q=1, otherwise go to RUN.
  - DONE: done=1, busy=0, results frozen. On start, clear and go to RUN.
- Latency: the sample edge is SETTLE_CYC cycles after the acceptance edge. Result registers update on the sample edge.
- Throughput: one vector per SETTLE_CYC+1 cycles.
- Compare at the sample edge:
  - vec_cnt increments, saturating at 2^CNT_W-1.
  - If z_obs!=z_exp: mismatch_cnt increments (saturating) and fault_detected is set.
  - If this is the first mismatch of the session: first_fail_vec=vec_out and first_fail_idx=vec_cnt (pre-increment value). These registers are never overwritten later in the session.
  - If saturation of vec_cnt occurs before the first fail, first_fail_idx holds the saturated value.
- start while busy is ignored. start and vec_valid in the same IDLE cycle: only start acts; the vector is not accepted (vec_ready was 0).
- vec_valid outside RUN is ignored. Vectors are never dropped: the source holds vec_valid/vec_in until accepted.
- X/Z on z_obs is not resolved; the comparison uses plain inequality.
- Reset mid-session aborts immediately to IDLE with all results cleared.

Optional Feature:
SA_SIG_EN
- Defined: signature is a SIG_W-bit MISR, initialised to all-ones on start. At each sample edge: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{1'b0}},z_obs}. For SIG_W=16, POLY=16'h1021.
- Undefined: no MISR logic is built and signature is tied to 0.

Test Plan:
1. Reset mid-SETTLE: apply rst_n=0 -> same cycle, vec_out=0, busy=0, done=0, all counters 0.
2. B stuck-at-1, SETTLE_CYC=2, vectors 0000,0100,0010(last): z_exp=0,1,0 and z_obs=1,1,0 -> fault_detected=1, mismatch_cnt=1, vec_cnt=3, first_fail_vec=0000, first_fail_idx=0, done=1. vec_ready is low for exactly 2 cycles after each accept.
3. All-match run of 5 vectors (z_obs=z_exp) -> fault_detected=0, mismatch_cnt=0, vec_cnt=5, first_fail_idx=0. Then start again -> results cleared, state RUN.
4. Mismatches at indices 3 and 6 of 8 vectors -> first_fail_idx=3 with that index's vector captured, mismatch_cnt=2. vec_valid held low for 4 cycles mid-run -> checker stays in RUN with vec_ready=1.
5. CNT_W=2, 6 vectors all mismatching -> mismatch_cnt=3 and vec_cnt=3 (saturated), no wrap. start asserted while busy -> ignored.
6. SA_SIG_EN, SIG_W=16, start then z_obs sequence 1,0,1 -> signature matches the bench MISR model (init 16'hFFFF, POLY 16'h1021). Without the macro, signature=0 throughout.
